// File: rtl/config_chain_loader_if.sv
// Bundle of the host stream, chain-side serial signals and status of the config chain loader.
interface config_chain_loader_if #(
    parameter int unsigned WORD_W = 32
);
    logic              start;
    logic [WORD_W-1:0] cfg_word;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              config_clk;
    logic              config_reset;
    logic              config_out;
    logic              config_in;
    logic              busy;
    logic              done;
    logic              error;

    // master: host plus chain tail; slave: the loader itself
    modport master (
        output start, cfg_word, cfg_valid, config_in,
        input  cfg_ready, config_clk, config_reset, config_out, busy, done, error
    );

    modport slave (
        input  start, cfg_word, cfg_valid, config_in,
        output cfg_ready, config_clk, config_reset, config_out, busy, done, error
    );
endinterface

// File: rtl/config_chain_loader.sv
// Serial configuration chain master: clears the chain, then shifts CHAIN_LEN bits out LSB first.
// Optional readback check via CRC-16-CCITT when CFG_VERIFY_EN is defined.
module config_chain_loader #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned CHAIN_LEN  = 64,
    parameter int unsigned RST_CYCLES = 4
) (
    input logic                  clk,
    input logic                  reset,
    config_chain_loader_if.slave bus
);
    localparam int unsigned REM_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WL_W  = $clog2(WORD_W + 1);
    localparam int unsigned RC_W  = $clog2(RST_CYCLES + 1);

`ifdef CFG_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_FETCH, S_SHIFT, S_VERIFY, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_FETCH, S_SHIFT, S_FIN} state_t;
`endif

    state_t            state, state_d;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_d;
    logic              phase, phase_d;
    logic [REM_W-1:0]  remaining, remaining_d;
    logic [WL_W-1:0]   word_left, word_left_d;
    logic [WORD_W-1:0] sreg, sreg_d;

    logic cfg_ready_q, cfg_ready_d;
    logic config_clk_q, config_clk_d;
    logic config_reset_q, config_reset_d;
    logic config_out_q, config_out_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic fire;
    logic last_bit;
    assign fire     = bus.cfg_valid && cfg_ready_q;
    assign last_bit = phase && (remaining == REM_W'(1));

`ifdef CFG_VERIFY_EN
    logic [15:0] crc_load, crc_load_d;
    logic [15:0] crc_verify, crc_verify_d;
    logic        error_q, error_d;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            rst_cnt        <= '0;
            phase          <= 1'b0;
            remaining      <= '0;
            word_left      <= '0;
            sreg           <= '0;
            cfg_ready_q    <= 1'b0;
            config_clk_q   <= 1'b0;
            config_reset_q <= 1'b0;
            config_out_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef CFG_VERIFY_EN
            crc_load       <= '0;
            crc_verify     <= '0;
            error_q        <= 1'b0;
`endif
        end else begin
            state          <= state_d;
            rst_cnt        <= rst_cnt_d;
            phase          <= phase_d;
            remaining      <= remaining_d;
            word_left      <= word_left_d;
            sreg           <= sreg_d;
            cfg_ready_q    <= cfg_ready_d;
            config_clk_q   <= config_clk_d;
            config_reset_q <= config_reset_d;
            config_out_q   <= config_out_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef CFG_VERIFY_EN
            crc_load       <= crc_load_d;
            crc_verify     <= crc_verify_d;
            error_q        <= error_d;
`endif
        end
    end

    // Next-state logic; a word ends on the phase-B cycle of its last bit
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (bus.start) state_d = S_CLR;
            S_CLR:   if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_d = S_FETCH;
            S_FETCH: if (fire) state_d = S_SHIFT;
            S_SHIFT: begin
                if (last_bit) begin
`ifdef CFG_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_FIN;
`endif
                end else if (phase && word_left == WL_W'(1)) begin
                    state_d = S_FETCH;
                end
            end
`ifdef CFG_VERIFY_EN
            S_VERIFY: if (last_bit) state_d = S_FIN;
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates and next values of the registered outputs
    always_comb begin
        rst_cnt_d   = rst_cnt;
        phase_d     = phase;
        remaining_d = remaining;
        word_left_d = word_left;
        sreg_d      = sreg;
`ifdef CFG_VERIFY_EN
        crc_load_d   = crc_load;
        crc_verify_d = crc_verify;
        error_d      = error_q;
`endif
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    rst_cnt_d   = '0;
                    phase_d     = 1'b0;
                    remaining_d = REM_W'(CHAIN_LEN);
`ifdef CFG_VERIFY_EN
                    crc_load_d   = 16'hFFFF;
                    crc_verify_d = 16'hFFFF;
                    error_d      = 1'b0;
`endif
                end
            end
            S_CLR: rst_cnt_d = rst_cnt + RC_W'(1);
            S_FETCH: begin
                if (fire) begin
                    sreg_d  = bus.cfg_word;
                    phase_d = 1'b0;
                    // The final word may carry more bits than the chain still needs
                    if (32'(remaining) >= WORD_W) word_left_d = WL_W'(WORD_W);
                    else                          word_left_d = WL_W'(remaining);
                end
            end
            S_SHIFT: begin
                if (!phase) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d     = 1'b0;
                    sreg_d      = sreg >> 1;
                    remaining_d = remaining - REM_W'(1);
                    word_left_d = word_left - WL_W'(1);
`ifdef CFG_VERIFY_EN
                    crc_load_d = crc_step(crc_load, sreg[0]);
                    if (last_bit) remaining_d = REM_W'(CHAIN_LEN);
`endif
                end
            end
`ifdef CFG_VERIFY_EN
            S_VERIFY: begin
                if (!phase) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d      = 1'b0;
                    remaining_d  = remaining - REM_W'(1);
                    crc_verify_d = crc_step(crc_verify, config_out_q);
                    if (last_bit) error_d = (crc_load != crc_verify_d);
                end
            end
`endif
            default: ;
        endcase

        cfg_ready_d    = (state_d == S_FETCH);
        config_reset_d = (state_d == S_CLR);
        done_d         = (state_d == S_FIN);
        busy_d         = (state_d != S_IDLE) && (state_d != S_FIN);
        config_clk_d   = 1'b0;
        config_out_d   = 1'b0;
        if (state_d == S_SHIFT) begin
            config_clk_d = phase_d;
            config_out_d = sreg_d[0];
        end
`ifdef CFG_VERIFY_EN
        // Recirculate: tail bit captured at the start of phase A, held through phase B
        if (state_d == S_VERIFY) begin
            config_clk_d = phase_d;
            config_out_d = phase_d ? config_out_q : bus.config_in;
        end
`endif
    end

    assign bus.cfg_ready    = cfg_ready_q;
    assign bus.config_clk   = config_clk_q;
    assign bus.config_reset = config_reset_q;
    assign bus.config_out   = config_out_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
`ifdef CFG_VERIFY_EN
    assign bus.error        = error_q;
`else
    assign bus.error        = 1'b0;
`endif
endmodule

// File: tb/tb_config_chain_loader.sv
// Randomized self-checking bench for config_chain_loader against a bit-level chain model.
module tb_config_chain_loader;
    localparam int unsigned W  = 32;
    localparam int unsigned N  = 40;
    localparam int unsigned R  = 4;
    localparam int unsigned NW = (N + W - 1) / W;
`ifdef CFG_VERIFY_EN
    localparam int unsigned PASSES = 2;
`else
    localparam int unsigned PASSES = 1;
`endif
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic reset;
    config_chain_loader_if #(.WORD_W(W)) bus();

    config_chain_loader #(.WORD_W(W), .CHAIN_LEN(N), .RST_CYCLES(R)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Chain model: bit i of chain_sr is the i-th bit shifted in; bit 0 sits at the tail
    logic [N-1:0] chain_sr = '0;
    logic cc_prev = 1'b0;
    int rises = 0, rst_hi = 0, clk_in_rst = 0, busy_hi = 0, done_hi = 0;
    bit inject;
    int flip_at;

    always @(negedge clk) begin
        if (bus.config_reset) begin
            chain_sr = '0;
            rst_hi++;
            if (bus.config_clk) clk_in_rst++;
        end
        if (bus.config_clk && !cc_prev) begin
            chain_sr = {bus.config_out, chain_sr[N-1:1]};
            rises++;
        end
        cc_prev = bus.config_clk;
        if (bus.busy) busy_hi++;
        if (bus.done) done_hi++;
        bus.config_in = chain_sr[0] ^ (inject && rises == flip_at);
    end

    function automatic logic [6:0] outs();
        return {bus.cfg_ready, bus.config_clk, bus.config_reset, bus.config_out,
                bus.busy, bus.done, bus.error};
    endfunction

    task automatic do_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input int stall,
                           input bit mid_start, input bit exp_err, input string tag);
        logic [W-1:0] words [NW];
        logic [N-1:0] exp_chain;
        int r0, b0, d0, c0, k0, r1, t;
        bit moved;
        words[0] = w0;
        words[1] = w1;
        for (int i = 0; i < int'(N); i++) exp_chain[i] = words[i / W][i % W];

        @(negedge clk);
        r0 = rises; b0 = busy_hi; d0 = done_hi; c0 = rst_hi; k0 = clk_in_rst;
        bus.start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_word = w0;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
        check({tag, "_err_clr"}, 64'(bus.error), 64'd0);

        for (int k = 0; k < int'(NW); k++) begin
            if (k > 0) begin
                if (stall > 0) begin
                    t = 0;
                    while (!bus.cfg_ready && t < LIMIT) begin @(negedge clk); t++; end
                    r1 = rises;
                    moved = 1'b0;
                    repeat (stall) begin
                        @(negedge clk);
                        if (bus.config_clk) moved = 1'b1;
                    end
                    check({tag, "_stall_clk"}, {63'(rises - r1), moved}, 64'd0);
                end
                bus.cfg_valid = 1'b1;
                bus.cfg_word = words[k];
            end
            t = 0;
            while (!bus.cfg_ready && t < LIMIT) begin @(negedge clk); t++; end
            check({tag, "_fetch_wait"}, 64'(t < LIMIT), 64'd1);
            @(negedge clk);
            bus.cfg_valid = 1'b0;
            bus.cfg_word = $urandom;
            if (k == 0 && mid_start) begin
                repeat (7) @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        end

        t = 0;
        while (!bus.done && t < LIMIT) begin @(negedge clk); t++; end
        check({tag, "_done_wait"}, 64'(t < LIMIT), 64'd1);
        check({tag, "_idle_at_done"}, {62'd0, bus.busy, bus.cfg_ready}, 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done_hi - d0), 64'd1);
        check({tag, "_rises"}, 64'(rises - r0), 64'(PASSES * N));
        check({tag, "_busy_cycles"}, 64'(busy_hi - b0), 64'(R + NW + stall + 2 * PASSES * N));
        check({tag, "_clr_cycles"}, 64'(rst_hi - c0), 64'(R));
        check({tag, "_clk_in_clr"}, 64'(clk_in_rst - k0), 64'd0);
        check({tag, "_error"}, 64'(bus.error), 64'(exp_err));
        if (!exp_err) check({tag, "_chain"}, 64'(chain_sr), 64'(exp_chain));
    endtask

    initial begin
        int t, r0;
        inject = 1'b0;
        flip_at = -1;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_word = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", 64'(outs()), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outs", 64'(outs()), 64'd0);

        do_load(32'hA5A5A5A5, 32'h000000C3, 0, 1'b0, 1'b0, "basic");
        do_load(32'hA5A5A5A5, 32'h000000C3, 20, 1'b0, 1'b0, "stall");
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            do_load(a, b, (i % 2 == 0) ? 0 : int'($urandom_range(1, 25)), i[0], 1'b0, "rand");
        end

        // Reset while shifting, then a clean reload with an ignored start pulse
        @(negedge clk);
        r0 = rises;
        bus.start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_word = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (rises - r0 < 17 && t < LIMIT) begin @(negedge clk); t++; end
        check("midrst_wait", 64'(t < LIMIT), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_outs", 64'(outs()), 64'd0);
        bus.cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_idle", 64'(outs()), 64'd0);
        do_load($urandom, $urandom, 0, 1'b1, 1'b0, "reload");

`ifdef CFG_VERIFY_EN
        // Corrupt one recirculated tail bit; error must latch and hold until the next start
        inject = 1'b1;
        flip_at = rises + int'(N) + 3;
        do_load($urandom, $urandom, 0, 1'b0, 1'b1, "inject");
        repeat (5) @(negedge clk);
        check("err_sticky", 64'(bus.error), 64'd1);
        inject = 1'b0;
        do_load($urandom, $urandom, 3, 1'b0, 1'b0, "post_inject");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
